// File: rtl/board_writer.sv
// board_writer: sole writer of one player's board RAM; locks pieces, clears full rows, wipes the board
module board_writer #(
  parameter int COLS = 10,
  parameter int ROWS = 20
) (
  input  logic        pclk,
  input  logic        rstn,
  input  logic        lock_req,
  input  logic        wipe_req,
  input  logic [4:0]  x,
  input  logic [4:0]  y,
  input  logic [4:0]  ptype,
  input  logic [15:0] mask,
  output logic [7:0]  raddr,
  input  logic [4:0]  rdata,
  output logic [7:0]  waddr,
  output logic [4:0]  wdata,
  output logic        we,
  output logic        busy,
  output logic        done,
  output logic [2:0]  lines
);
  typedef enum logic [2:0] {IDLE, WIPE, LOCK, SCAN, SHIFT, DONE} state_t;
  localparam logic [7:0] LAST  = 8'(COLS * ROWS - 1);
  localparam logic [3:0] CEND  = 4'(COLS - 1);
  localparam logic [3:0] CEVAL = 4'(COLS);
  localparam logic [4:0] RBOT  = 5'(ROWS - 1);
  state_t state, state_n;
  logic [4:0]  px, py, r, dst;
  logic [2:0]  colour, cnt;
  logic [15:0] pmask;
  logic [7:0]  idx;
  logic [3:0]  col;
  logic        ph, full;
  logic [5:0]  lc, lr;
  logic        lin, row_full, req, unused_rot;
  function automatic logic [7:0] addr_of(input logic [4:0] row, input logic [3:0] c);
    return 8'(row) * 8'(COLS) + 8'(c);
  endfunction
  assign req        = wipe_req | lock_req;
  assign lc         = 6'(px) + 6'(idx[1:0]);
  assign lr         = 6'(py) + 6'(idx[3:2]);
  assign lin        = pmask[idx[3:0]] && lc < 6'(COLS) && lr < 6'(ROWS);
  assign row_full   = full && rdata != 5'd0;
  assign lines      = cnt;
  assign busy       = state != IDLE && state != DONE;
  assign done       = state == DONE;
  assign unused_rot = ^ptype[1:0];
  // state register, aborts straight to IDLE on reset
  always_ff @(posedge pclk or negedge rstn)
    if (!rstn) state <= IDLE;
    else state <= state_n;
  // next state and RAM port drive; the scan column COLS only evaluates the last read
  always_comb begin
    state_n = state;
    raddr   = '0;
    waddr   = '0;
    wdata   = '0;
    we      = 1'b0;
    case (state)
      IDLE:  state_n = wipe_req ? WIPE : lock_req ? LOCK : IDLE;
      WIPE: begin
        we      = 1'b1;
        waddr   = idx;
        state_n = idx == LAST ? DONE : WIPE;
      end
      LOCK: begin
        we      = lin;
        waddr   = lin ? addr_of(lr[4:0], lc[3:0]) : '0;
        wdata   = lin ? {2'b00, colour} : '0;
        state_n = idx[3:0] == 4'hF ? SCAN : LOCK;
      end
      SCAN: begin
        raddr   = addr_of(r, col == CEVAL ? 4'd0 : col);
        state_n = col != CEVAL ? SCAN : row_full ? SHIFT : r == 5'd0 ? DONE : SCAN;
      end
      SHIFT: begin
        raddr   = dst != 5'd0 && !ph ? addr_of(dst - 5'd1, col) : '0;
        we      = dst == 5'd0 || ph;
        waddr   = addr_of(dst, col);
        wdata   = dst == 5'd0 ? 5'd0 : rdata;
        state_n = dst == 5'd0 && col == CEND ? SCAN : SHIFT;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  // request capture, counters and row bookkeeping
  always_ff @(posedge pclk or negedge rstn)
    if (!rstn) begin
      px     <= '0;
      py     <= '0;
      colour <= '0;
      pmask  <= '0;
      idx    <= '0;
      cnt    <= '0;
      r      <= '0;
      dst    <= '0;
      col    <= '0;
      ph     <= 1'b0;
      full   <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req) begin
          px     <= x;
          py     <= y;
          colour <= ptype[4:2];
          pmask  <= mask;
          idx    <= '0;
          cnt    <= '0;
        end
        WIPE: idx <= idx + 8'd1;
        LOCK: begin
          idx <= idx + 8'd1;
          r   <= RBOT;
          col <= '0;
        end
        SCAN: begin
          col  <= col == CEVAL ? 4'd0 : col + 4'd1;
          full <= col == 4'd0 ? 1'b1 : full && rdata != 5'd0;
          if (col == CEVAL && row_full) begin
            cnt <= cnt == 3'd4 ? cnt : cnt + 3'd1;
            dst <= r;
            ph  <= 1'b0;
          end else if (col == CEVAL) r <= r - 5'd1;
        end
        SHIFT: begin
          ph <= dst != 5'd0 && !ph;
          if (dst == 5'd0 || ph) begin
            col <= col == CEND ? 4'd0 : col + 4'd1;
            if (dst != 5'd0 && col == CEND) dst <= dst - 5'd1;
          end
        end
        default: ;
      endcase
    end
endmodule
